// File: rtl/switch_debounce_filter_if.sv
// Switch conditioning signal bundle: raw pin toward the filter, conditioned levels back.
// Edge strobes exist only when SWITCH_EDGE_EN is defined.
interface switch_debounce_filter_if;
    logic i_Switch;
    logic o_Switch;
    logic o_Toggle;
`ifdef SWITCH_EDGE_EN
    logic o_Rise;
    logic o_Fall;
`endif

    modport master (
        output i_Switch,
        input  o_Switch,
        input  o_Toggle
`ifdef SWITCH_EDGE_EN
        ,
        input  o_Rise,
        input  o_Fall
`endif
    );

    modport slave (
        input  i_Switch,
        output o_Switch,
        output o_Toggle
`ifdef SWITCH_EDGE_EN
        ,
        output o_Rise,
        output o_Fall
`endif
    );
endinterface

// File: rtl/switch_debounce_filter.sv
// Synchronizes and debounces one mechanical switch; provides clean level and press toggle.
// Optional macro SWITCH_EDGE_EN adds registered one-cycle rise/fall strobes.
module switch_debounce_filter #(
    parameter int   DEBOUNCE_LIMIT = 250000,
    parameter int   SYNC_STAGES    = 2,
    parameter logic RESET_LEVEL    = 1'b0
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    switch_debounce_filter_if.slave sw
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_out_s;
    state_t                 state_r, state_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic                   switch_r, switch_s;
    logic                   toggle_r, toggle_s;
    logic                   accept_s;
`ifdef SWITCH_EDGE_EN
    logic                   rise_r, rise_s;
    logic                   fall_r, fall_s;
`endif

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Metastability chain for the asynchronous pin
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync_r <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sw.i_Switch};
        end
    end

    // Qualification FSM next-state and output-update logic
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        switch_s = switch_r;
        toggle_s = toggle_r;
        accept_s = 1'b0;
`ifdef SWITCH_EDGE_EN
        rise_s   = 1'b0;
        fall_s   = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (sync_out_s != switch_r) begin
                    if (DEBOUNCE_LIMIT == 32'sd1) begin
                        accept_s = 1'b1;
                        cnt_s    = CNT_ZERO;
                    end else begin
                        state_s = ST_COUNT;
                        cnt_s   = CNT_ONE;
                    end
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            ST_COUNT: begin
                // Any return to the accepted level throws away partial progress
                if (sync_out_s == switch_r) begin
                    state_s = ST_IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_s  = ST_IDLE;
                    cnt_s    = CNT_ZERO;
                    accept_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase

        if (accept_s) begin
            switch_s = sync_out_s;
            if (sync_out_s) begin
                toggle_s = ~toggle_r;
`ifdef SWITCH_EDGE_EN
                rise_s   = 1'b1;
`endif
            end else begin
`ifdef SWITCH_EDGE_EN
                fall_s   = 1'b1;
`endif
            end
        end else begin
            switch_s = switch_r;
        end
    end

    // State, counter and output registers
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            switch_r <= RESET_LEVEL;
            toggle_r <= 1'b0;
`ifdef SWITCH_EDGE_EN
            rise_r   <= 1'b0;
            fall_r   <= 1'b0;
`endif
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            switch_r <= switch_s;
            toggle_r <= toggle_s;
`ifdef SWITCH_EDGE_EN
            rise_r   <= rise_s;
            fall_r   <= fall_s;
`endif
        end
    end

    assign sw.o_Switch = switch_r;
    assign sw.o_Toggle = toggle_r;
`ifdef SWITCH_EDGE_EN
    assign sw.o_Rise   = rise_r;
    assign sw.o_Fall   = fall_r;
`endif

endmodule

// File: tb/tb_switch_debounce_filter.sv
// Bench for switch_debounce_filter: directed scenarios plus randomized pin activity
// compared against a window-based reference model.
module tb_switch_debounce_filter;

    localparam int LIM_A  = 4;
    localparam int SYNC_A = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    switch_debounce_filter_if if_a();
    switch_debounce_filter_if if_b();

    switch_debounce_filter #(.DEBOUNCE_LIMIT(LIM_A), .SYNC_STAGES(SYNC_A), .RESET_LEVEL(1'b0)) dut_a (
        .i_Clk (clk),
        .i_Rst (rst_a),
        .sw    (if_a)
    );

    switch_debounce_filter #(.DEBOUNCE_LIMIT(1), .SYNC_STAGES(2), .RESET_LEVEL(1'b1)) dut_b (
        .i_Clk (clk),
        .i_Rst (rst_b),
        .sw    (if_b)
    );

    // Reference model for dut_a: s is the pin delayed SYNC_A edges; the output flips
    // once the last LIM_A values of s all differ from it.
    logic pin_q[$];
    logic s_hist[$];
    logic m_out, m_tog, m_rise, m_fall;

    task automatic model_reset();
        pin_q = {};
        for (int i = 0; i < SYNC_A; i++) pin_q.push_back(1'b0);
        s_hist = {};
        m_out  = 1'b0;
        m_tog  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
    endtask

    task automatic model_edge(input logic p);
        logic s;
        bit   all_diff;
        s = pin_q.pop_front();
        pin_q.push_back(p);
        s_hist.push_back(s);
        if (s_hist.size() > LIM_A) void'(s_hist.pop_front());
        m_rise = 1'b0;
        m_fall = 1'b0;
        all_diff = (s_hist.size() == LIM_A);
        foreach (s_hist[i]) if (s_hist[i] == m_out) all_diff = 1'b0;
        if (all_diff) begin
            m_out = ~m_out;
            if (m_out) begin
                m_tog  = ~m_tog;
                m_rise = 1'b1;
            end else begin
                m_fall = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_a) model_reset();
        else model_edge(if_a.i_Switch);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.i_Switch = 1'b0;
        if_b.i_Switch = 1'b1;
        model_reset();
        tick();
        tick();
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        checks++;
        if (if_a.o_Switch !== 1'b0) begin errors++; $display("FAIL reset_a_switch got=%b exp=0", if_a.o_Switch); end
        checks++;
        if (if_a.o_Toggle !== 1'b0) begin errors++; $display("FAIL reset_a_toggle got=%b exp=0", if_a.o_Toggle); end
        checks++;
        if (if_b.o_Switch !== 1'b1) begin errors++; $display("FAIL reset_b_switch got=%b exp=1", if_b.o_Switch); end
        checks++;
        if (if_b.o_Toggle !== 1'b0) begin errors++; $display("FAIL reset_b_toggle got=%b exp=0", if_b.o_Toggle); end
`ifdef SWITCH_EDGE_EN
        checks++;
        if (if_a.o_Rise !== 1'b0 || if_a.o_Fall !== 1'b0) begin
            errors++; $display("FAIL reset_edges got=%b%b exp=00", if_a.o_Rise, if_a.o_Fall);
        end
`endif
    endtask

    task automatic test_clean_press();
        logic tog0;
        tog0 = if_a.o_Toggle;
        if_a.i_Switch = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            checks++;
            if (if_a.o_Switch !== (n >= 6)) begin
                errors++; $display("FAIL press_edge%0d got=%b exp=%b", n, if_a.o_Switch, (n >= 6));
            end
            checks++;
            if (if_a.o_Toggle !== ((n >= 6) ? ~tog0 : tog0)) begin
                errors++; $display("FAIL press_toggle_edge%0d got=%b", n, if_a.o_Toggle);
            end
`ifdef SWITCH_EDGE_EN
            checks++;
            if (if_a.o_Rise !== (n == 6) || if_a.o_Fall !== 1'b0) begin
                errors++; $display("FAIL press_rise_edge%0d got=%b%b", n, if_a.o_Rise, if_a.o_Fall);
            end
`endif
        end
    endtask

    task automatic test_release_repress();
        logic tog0;
        tog0 = if_a.o_Toggle;
        if_a.i_Switch = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
`ifdef SWITCH_EDGE_EN
            checks++;
            if (if_a.o_Fall !== (n == 6) || if_a.o_Rise !== 1'b0) begin
                errors++; $display("FAIL release_fall_edge%0d got=%b%b", n, if_a.o_Rise, if_a.o_Fall);
            end
`endif
        end
        checks++;
        if (if_a.o_Switch !== 1'b0) begin errors++; $display("FAIL release_switch got=%b exp=0", if_a.o_Switch); end
        checks++;
        if (if_a.o_Toggle !== tog0) begin errors++; $display("FAIL release_toggle got=%b exp=%b", if_a.o_Toggle, tog0); end
        if_a.i_Switch = 1'b1;
        repeat (10) tick();
        checks++;
        if (if_a.o_Switch !== 1'b1) begin errors++; $display("FAIL repress_switch got=%b exp=1", if_a.o_Switch); end
        checks++;
        if (if_a.o_Toggle !== ~tog0) begin errors++; $display("FAIL repress_toggle got=%b exp=%b", if_a.o_Toggle, ~tog0); end
        if_a.i_Switch = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_bounce();
        if_a.i_Switch = 1'b0;
        repeat (8) tick();
        if_a.i_Switch = 1'b1;
        repeat (3) tick();
        if_a.i_Switch = 1'b0;
        tick();
        if_a.i_Switch = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            checks++;
            if (if_a.o_Switch !== (n >= 6)) begin
                errors++; $display("FAIL bounce_edge%0d got=%b exp=%b", n, if_a.o_Switch, (n >= 6));
            end
        end
    endtask

    task automatic test_reset_mid_count();
        if_a.i_Switch = 1'b0;
        repeat (8) tick();
        if_a.i_Switch = 1'b1;
        repeat (4) tick();
        rst_a = 1'b1;
        model_reset();
        #1;
        checks++;
        if (if_a.o_Switch !== 1'b0) begin errors++; $display("FAIL midrst_async got=%b exp=0", if_a.o_Switch); end
        tick();
        @(negedge clk);
        rst_a = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            tick();
            checks++;
            if (if_a.o_Switch !== (n >= 6)) begin
                errors++; $display("FAIL midrst_edge%0d got=%b exp=%b", n, if_a.o_Switch, (n >= 6));
            end
        end
    endtask

    task automatic test_reset_level_high();
        if_b.i_Switch = 1'b1;
        rst_b = 1'b1;
        tick();
        @(negedge clk);
        rst_b = 1'b0;
        repeat (4) tick();
        checks++;
        if (if_b.o_Switch !== 1'b1 || if_b.o_Toggle !== 1'b0) begin
            errors++; $display("FAIL rl1_exit got=%b%b exp=10", if_b.o_Switch, if_b.o_Toggle);
        end
        if_b.i_Switch = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            tick();
            checks++;
            if (if_b.o_Switch !== (n < 3)) begin
                errors++; $display("FAIL rl1_fall_edge%0d got=%b exp=%b", n, if_b.o_Switch, (n < 3));
            end
`ifdef SWITCH_EDGE_EN
            checks++;
            if (if_b.o_Fall !== (n == 3)) begin
                errors++; $display("FAIL rl1_fallstrobe_edge%0d got=%b", n, if_b.o_Fall);
            end
`endif
        end
        if_b.i_Switch = 1'b1;
        repeat (3) tick();
        checks++;
        if (if_b.o_Switch !== 1'b1 || if_b.o_Toggle !== 1'b1) begin
            errors++; $display("FAIL rl1_press got=%b%b exp=11", if_b.o_Switch, if_b.o_Toggle);
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                if_a.i_Switch = 1'($urandom_range(0, 1));
                hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 12)) : int'($urandom_range(1, 5));
            end
            hold--;
            rst_a = ($urandom_range(0, 149) == 0);
            tick();
            rst_a = 1'b0;
            checks++;
            if (if_a.o_Switch !== m_out) begin errors++; $display("FAIL rand_switch cyc=%0d got=%b exp=%b", i, if_a.o_Switch, m_out); end
            checks++;
            if (if_a.o_Toggle !== m_tog) begin errors++; $display("FAIL rand_toggle cyc=%0d got=%b exp=%b", i, if_a.o_Toggle, m_tog); end
`ifdef SWITCH_EDGE_EN
            checks++;
            if (if_a.o_Rise !== m_rise || if_a.o_Fall !== m_fall) begin
                errors++; $display("FAIL rand_edges cyc=%0d got=%b%b exp=%b%b", i, if_a.o_Rise, if_a.o_Fall, m_rise, m_fall);
            end
            checks++;
            if (if_a.o_Rise === 1'b1 && if_a.o_Fall === 1'b1) begin
                errors++; $display("FAIL rand_both_edges cyc=%0d got=11 exp=not both", i);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_repress();
        test_bounce();
        test_reset_mid_count();
        test_reset_level_high();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_debounce_filter.md
Name: switch_debounce_filter

Overview:
- Conditions one raw mechanical switch input before it drives the board's combinational switch-to-LED logic, such as the 2-input AND gate project.
- Synchronizes the asynchronous pin into i_Clk and rejects bounce shorter than DEBOUNCE_LIMIT cycles.
- Outputs a clean level, a press-toggled level, and optional single-cycle edge strobes.
- One instance per switch; outputs feed the downstream gate inputs directly.

Parameters:
- DEBOUNCE_LIMIT, 250000, consecutive stable cycles required before a level change is accepted (10 ms at 25 MHz); legal range >= 1.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer; legal range >= 2.
- RESET_LEVEL, 1'b0, value loaded into the synchronizer and o_Switch during reset.

Ports:
- i_Clk  input  1  system clock; all state updates on the rising edge.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Switch  input  1  raw switch pin; asynchronous to i_Clk, may bounce.
- o_Switch  output  1  debounced switch level.
- o_Toggle  output  1  inverts on every accepted 0->1 transition of o_Switch.
- o_Rise  output  1  one-cycle strobe on an accepted 0->1 transition (present only with SWITCH_EDGE_EN).
- o_Fall  output  1  one-cycle strobe on an accepted 1->0 transition (present only with SWITCH_EDGE_EN).

Behaviour:
- Reset (i_Rst=1, asynchronous):
  - All synchronizer stages = RESET_LEVEL; o_Switch = RESET_LEVEL.
  - o_Toggle = 0; o_Rise = o_Fall = 0; count = 0; state = IDLE.
  - Reset asserted mid-count discards all progress.
  - First active edge is the first rising i_Clk after i_Rst falls.
- Synchronizer: shift chain of SYNC_STAGES flops. s = last stage. Only s is used downstream.
- Counter:
  - Width is $clog2(DEBOUNCE_LIMIT+1).
  - Never exceeds DEBOUNCE_LIMIT-1, so it never wraps.
- State machine, evaluated each rising edge:
  - IDLE, s == o_Switch: stay; count = 0.
  - IDLE, s != o_Switch, DEBOUNCE_LIMIT == 1: o_Switch <= s this edge; stay IDLE.
  - IDLE, s != o_Switch, DEBOUNCE_LIMIT > 1: go COUNT; count <= 1.
  - COUNT, s == o_Switch: glitch rejected; go IDLE; count <= 0; o_Switch unchanged.
  - COUNT, s != o_Switch, count < DEBOUNCE_LIMIT-1: count <= count+1.
  - COUNT, s != o_Switch, count == DEBOUNCE_LIMIT-1: o_Switch <= s; count <= 0; go IDLE.
- Latency:
  - Number edges from 1, where edge 1 is the first rising edge that samples the new i_Switch level.
  - For a clean step held long enough, o_Switch changes on edge SYNC_STAGES + DEBOUNCE_LIMIT.
- Bounce rejection: any return of s to o_Switch's value before acceptance restarts qualification from zero. Partial counts are never kept.
- o_Toggle:
  - Updates on the same edge as an accepted o_Switch 0->1 change.
  - Unaffected by 1->0 changes.
  - No-op on reset exit, even if RESET_LEVEL=1 and the pin is high.
- Outputs are registered; no combinational path from i_Switch to any output.

Optional Feature:
- Macro: SWITCH_EDGE_EN.
- Defined:
  - o_Rise/o_Fall ports exist and are registered.
  - On the edge o_Switch goes 0->1, o_Rise = 1 for exactly one cycle.
  - On the edge o_Switch goes 1->0, o_Fall = 1 for exactly one cycle.
  - Never both high. Both low in all other cycles and during reset.
- Undefined: ports and edge-detect logic are absent. All other behaviour is identical.

Test Plan (DEBOUNCE_LIMIT=4, SYNC_STAGES=2, RESET_LEVEL=0 unless noted):
- Reset then clean press: i_Rst 1->0 with i_Switch=0 -> o_Switch=0, o_Toggle=0. Then i_Switch=1 held -> o_Switch=1 exactly on edge 6; o_Toggle=1 on edge 6.
- Bounce rejection: i_Switch=1 for 3 cycles, 0 for 1, 1 held -> o_Switch stays 0 until 6 edges after the final 0->1 sample.
- Release and re-press: press then release, each held 10 cycles -> o_Switch returns to 0, o_Toggle stays 1. Second press -> o_Toggle=0.
- Reset mid-count: i_Switch=1 held; assert i_Rst after edge 4 for 1 cycle, then release -> o_Switch=0 and count=0 immediately; o_Switch=1 on edge 6 after reset release.
- RESET_LEVEL=1, DEBOUNCE_LIMIT=1, pin held 1 through reset -> o_Switch=1, o_Toggle=0 after reset. Pin 0 -> o_Switch=0 on edge 3.
- With SWITCH_EDGE_EN: press then release -> o_Rise=1 for one cycle coincident with o_Switch 0->1; o_Fall=1 for one cycle coincident with 1->0; never both high.
